// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bus bundle between the data-memory arbiter, its two requesters and the
// single-port data memory.
//   m0_*      : core load/store stage (req/we/addr/wdata in, gnt/stall/rvalid out)
//   m1_*      : program loader / debug port, same as m0 plus m1_lock
//   rdata     : read data returned to both requesters (copy of mem_Out)
//   mem_*     : memory address, write data, read/write strobes, registered read data
//   contention: saturating count of cycles in which any request was denied
//   lock_dbg  : lock state observation (1 = m1 holds the memory)
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the memory (the environment of the arbiter)
//
// Handshake: a transfer happens at the rising edge where mX_req & mX_gnt are
// both high; mX_gnt is combinational in the same cycle. Read data is presented
// on rdata with mX_rvalid exactly one cycle after the granted read.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int n  = 5,
   parameter int l  = 32,
   parameter int CW = 16
);
   logic          m0_req;
   logic          m0_we;
   logic [n-1:0]  m0_addr;
   logic [l-1:0]  m0_wdata;
   logic          m0_gnt;
   logic          m0_stall;
   logic          m0_rvalid;

   logic          m1_req;
   logic          m1_we;
   logic [n-1:0]  m1_addr;
   logic [l-1:0]  m1_wdata;
   logic          m1_lock;
   logic          m1_gnt;
   logic          m1_stall;
   logic          m1_rvalid;

   logic [l-1:0]  rdata;
   logic [n-1:0]  mem_Ad;
   logic [l-1:0]  mem_Data;
   logic          mem_r;
   logic          mem_w;
   logic [l-1:0]  mem_Out;

   logic [CW-1:0] contention;
   logic          lock_dbg;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      input  mem_Out,
      output m0_gnt, m0_stall, m0_rvalid,
      output m1_gnt, m1_stall, m1_rvalid,
      output rdata, mem_Ad, mem_Data, mem_r, mem_w,
      output contention, lock_dbg
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
      output mem_Out,
      input  m0_gnt, m0_stall, m0_rvalid,
      input  m1_gnt, m1_stall, m1_rvalid,
      input  rdata, mem_Ad, mem_Data, mem_r, mem_w,
      input  contention, lock_dbg
   );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory (read data registered, valid the cycle
// after the read strobe) between the core (m0) and the loader/debug port (m1).
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : dmem_arbiter_if.slave - requester handshakes, memory side,
//            contention counter and lock-state observation
// Parameters:
//   n  address width, l data width,
//   RR 1 = round-robin on a tie, 0 = m0 always wins a tie,
//   CW width of the saturating contention counter
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int n  = 5,
   parameter int l  = 32,
   parameter int RR = 1,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic {FREE = 1'b0, LOCK1 = 1'b1} lock_state_t;

   localparam logic LAST_M0 = 1'b0;
   localparam logic LAST_M1 = 1'b1;

   lock_state_t   state_q;
   logic          last_q, last_d;
   logic          m0_rvalid_q, m1_rvalid_q;
   logic [CW-1:0] cont_q, cont_d;

   logic          m0_gnt, m1_gnt, any_gnt, we_sel;
   logic          m0_stall, m1_stall;
   logic [n-1:0]  addr_sel;
   logic [l-1:0]  data_sel;

   // Grant decision. While m1 holds the lock it gets the memory whenever it
   // asks and m0 is shut out; otherwise a tie goes to m0 (fixed priority) or
   // to whichever master did not win most recently (round-robin).
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!reset) begin
         if (state_q == LOCK1) begin
            m1_gnt = bus.m1_req;
         end else if (bus.m0_req && bus.m1_req) begin
            if ((RR != 0) && (last_q == LAST_M0)) m1_gnt = 1'b1;
            else                                  m0_gnt = 1'b1;
         end else begin
            m0_gnt = bus.m0_req;
            m1_gnt = bus.m1_req;
         end
      end
   end

   assign any_gnt  = m0_gnt | m1_gnt;
   assign we_sel   = m1_gnt ? bus.m1_we    : bus.m0_we;
   // m0's fields are presented when nobody is granted.
   assign addr_sel = m1_gnt ? bus.m1_addr  : bus.m0_addr;
   assign data_sel = m1_gnt ? bus.m1_wdata : bus.m0_wdata;

   // Grants are already zero in reset; the explicit gate keeps stall low too.
   assign m0_stall = ~reset & bus.m0_req & ~m0_gnt;
   assign m1_stall = ~reset & bus.m1_req & ~m1_gnt;

   assign bus.m0_gnt     = m0_gnt;
   assign bus.m1_gnt     = m1_gnt;
   assign bus.m0_stall   = m0_stall;
   assign bus.m1_stall   = m1_stall;
   assign bus.mem_Ad     = addr_sel;
   assign bus.mem_Data   = data_sel;
   assign bus.mem_r      = any_gnt & ~we_sel;
   assign bus.mem_w      = any_gnt &  we_sel;
   assign bus.rdata      = bus.mem_Out;
   // A read pending across a reset edge is dropped; gating here also keeps
   // rvalid low during the reset cycle itself.
   assign bus.m0_rvalid  = m0_rvalid_q & ~reset;
   assign bus.m1_rvalid  = m1_rvalid_q & ~reset;
   assign bus.contention = cont_q;
   assign bus.lock_dbg   = (state_q == LOCK1);

   always_comb begin
      last_d = last_q;
      if (m0_gnt)      last_d = LAST_M0;
      else if (m1_gnt) last_d = LAST_M1;

      cont_d = cont_q;
      if ((m0_stall || m1_stall) && (cont_q != {CW{1'b1}}))
         cont_d = cont_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FREE;
         last_q      <= LAST_M1;   // m0 wins the first tie after reset
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         cont_q      <= '0;
      end else begin
         // The lock is only taken on a cycle m1 was granted normally, so it
         // never steals a cycle already given to m0.
         case (state_q)
            FREE:    if (m1_gnt && bus.m1_lock)         state_q <= LOCK1;
            LOCK1:   if (!bus.m1_req || !bus.m1_lock)  state_q <= FREE;
            default:                                   state_q <= FREE;
         endcase
         last_q      <= last_d;
         m0_rvalid_q <= m0_gnt & ~bus.m0_we;
         m1_rvalid_q <= m1_gnt & ~bus.m1_we;
         cont_q      <= cont_d;
      end
   end
endmodule
